// File: rtl/serial_load_rx.sv
// Framed serial receiver feeding a counter's parallel-load port: synchronises sdi/sclk/cs_n,
// checks framing and emits load_pulse/frame_err strobes. Optional parity via SERIAL_LOAD_RX_PARITY_EN.
module serial_load_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdi,
  input  logic             sclk,
  input  logic             cs_n,
  output logic [WIDTH-1:0] load_data,
  output logic             load_pulse,
  output logic             frame_err,
  output logic             busy
);

`ifdef SERIAL_LOAD_RX_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DRAIN} state_t;

  // Tap SYNC_STAGES is a history flop; edges compare it with the last synchroniser tap.
  logic [SYNC_STAGES:0]   r_sclk_sync;
  logic [SYNC_STAGES:0]   r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sclk_rise;
  logic                   r_cs_rise;
  logic                   r_cs_fall;
  logic                   r_sdi_bit;

  state_t                  r_state;
  logic [FRAME_BITS-1:0]   r_sh;
  logic [CNT_W-1:0]        r_cnt;
  logic [TO_W-1:0]         r_to_cnt;

  logic [FRAME_BITS-1:0]   w_sh_next;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    w_full;
  logic                    w_parity_ok;
  logic                    w_timeout;
  logic [TO_W-1:0]         w_to_next;

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_sdi_sync  <= '0;
      r_sclk_rise <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_sdi_bit   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-1:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-1:0], cs_n};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_sclk_rise <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_sync[SYNC_STAGES];
      r_cs_rise   <= r_cs_sync[SYNC_STAGES-1] & ~r_cs_sync[SYNC_STAGES];
      r_cs_fall   <= ~r_cs_sync[SYNC_STAGES-1] & r_cs_sync[SYNC_STAGES];
      r_sdi_bit   <= r_sdi_sync[SYNC_STAGES-1];
    end
  end

  // The sclk bit of this cycle is folded in before cs_n is evaluated.
  assign w_sh_next  = r_sclk_rise ? {r_sdi_bit, r_sh[FRAME_BITS-1:1]} : r_sh;
  assign w_cnt_next = r_cnt + CNT_W'(r_sclk_rise);
  assign w_full     = (w_cnt_next == CNT_W'(FRAME_BITS));
  assign w_timeout  = !r_sclk_rise && (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_to_next  = r_sclk_rise ? '0 : r_to_cnt + 1'b1;
`ifdef SERIAL_LOAD_RX_PARITY_EN
  assign w_parity_ok = ~^w_sh_next;
`else
  assign w_parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sh       <= '0;
      r_cnt      <= '0;
      r_to_cnt   <= '0;
      load_data  <= '0;
      load_pulse <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_cs_fall) begin
            r_state  <= SHIFT;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_to_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          r_sh     <= w_sh_next;
          r_cnt    <= w_cnt_next;
          r_to_cnt <= w_to_next;
          if (r_cs_rise) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            if (w_full && w_parity_ok) begin
              load_data  <= w_sh_next[WIDTH-1:0];
              load_pulse <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (w_timeout) begin
            frame_err <= 1'b1;
            r_state   <= DRAIN;
          end else if (w_full) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_to_cnt <= w_to_next;
          if (r_sclk_rise) begin
            if (r_cs_rise) begin
              frame_err <= 1'b1;
              r_state   <= IDLE;
              busy      <= 1'b0;
            end else begin
              r_state <= DRAIN;
            end
          end else if (r_cs_rise) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            if (w_parity_ok) begin
              load_data  <= r_sh[WIDTH-1:0];
              load_pulse <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (w_timeout) begin
            frame_err <= 1'b1;
            r_state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_cs_rise) begin
            // Suppressed only when the timeout strobe fired last cycle, keeping strobes apart.
            frame_err <= !frame_err;
            r_state   <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_load_rx.sv
// Directed bench for serial_load_rx: good frames, short/long frames, timeout, back-to-back
// frames, reset mid-frame and (with SERIAL_LOAD_RX_PARITY_EN) parity accept/reject.
module tb_serial_load_rx;
  localparam int WIDTH   = 8;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 255;
`ifdef SERIAL_LOAD_RX_PARITY_EN
  localparam int FB = WIDTH + 1;
`else
  localparam int FB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sdi = 1'b0;
  logic             sclk = 1'b0;
  logic             cs_n = 1'b1;
  logic [WIDTH-1:0] load_data;
  logic             load_pulse;
  logic             frame_err;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor-owned counters; the stimulus only reads them.
  int               n_pulse = 0;
  int               n_ferr = 0;
  int               n_viol = 0;
  logic             prev_strobe = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [WIDTH-1:0] pulse_data[$];

  serial_load_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sdi       (sdi),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .load_data (load_data),
    .load_pulse(load_pulse),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (load_pulse) begin
        n_pulse++;
        pulse_data.push_back(load_data);
      end
      if (frame_err) n_ferr++;
      if (load_pulse && frame_err) n_viol++;
      if ((load_pulse || frame_err) && prev_strobe) n_viol++;
      if ((load_data !== prev_data) && !load_pulse) n_viol++;
    end
    prev_strobe = load_pulse | frame_err;
    prev_data   = load_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    wait_clk(3);
    sclk = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
    wait_clk(1);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic end_frame();
    wait_clk(2);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  function automatic logic [15:0] word_bits(input logic [WIDTH-1:0] w);
    return {7'd0, ^w, w};
  endfunction

  initial begin
    int base_p, base_e, base_q, k;

    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    check("reset_load_data", load_data, 0);
    check("reset_load_pulse", load_pulse, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);

    // Good frame 0xA5 plus load latency measured from the first edge that sees cs_n high.
    base_p = n_pulse; base_e = n_ferr;
    start_frame();
    send_bits(word_bits(8'hA5), 1);
    check("a5_busy_mid", busy, 1);
    send_bits(word_bits(8'hA5) >> 1, FB - 1);
    wait_clk(2);
    cs_n = 1'b1;
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      @(negedge clk);
      if (load_pulse) break;
      k++;
    end
    check("a5_latency", k, SYNC + 1);
    wait_clk(8);
    check("a5_pulses", n_pulse - base_p, 1);
    check("a5_errs", n_ferr - base_e, 0);
    check("a5_data", load_data, 8'hA5);
    check("a5_busy_after", busy, 0);

    // Short frame: 5 bits.
    base_p = n_pulse; base_e = n_ferr;
    start_frame();
    send_bits(16'h0015, 5);
    end_frame();
    check("short_errs", n_ferr - base_e, 1);
    check("short_pulses", n_pulse - base_p, 0);
    check("short_data", load_data, 8'hA5);

    // Overrun: one sclk rise beyond the frame length.
    base_p = n_pulse; base_e = n_ferr;
    start_frame();
    send_bits(16'h03FF, FB + 1);
    end_frame();
    check("overrun_errs", n_ferr - base_e, 1);
    check("overrun_pulses", n_pulse - base_p, 0);
    check("overrun_data", load_data, 8'hA5);

    // Timeout: 3 bits then sclk stops; abort expected 255 idle cycles after the last rise.
    base_p = n_pulse; base_e = n_ferr;
    start_frame();
    send_bits(16'h0005, 3);
    k = 0;
    while (k < 300 && !frame_err) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check("timeout_window", (k >= 245 && k <= 260), 1);
    wait_clk(300 - k);
    check("timeout_errs", n_ferr - base_e, 1);
    check("timeout_busy_held", busy, 1);
    cs_n = 1'b1;
    wait_clk(10);
    check("timeout_busy_released", busy, 0);
    check("timeout_pulses", n_pulse - base_p, 0);
    check("timeout_data", load_data, 8'hA5);

    // Back-to-back frames with a single-clock cs_n high gap.
    base_p = n_pulse; base_e = n_ferr; base_q = pulse_data.size();
    start_frame();
    send_bits(word_bits(8'h3C), FB);
    wait_clk(2);
    cs_n = 1'b1;
    wait_clk(1);
    cs_n = 1'b0;
    wait_clk(4);
    send_bits(word_bits(8'hFF), FB);
    end_frame();
    check("b2b_pulses", n_pulse - base_p, 2);
    check("b2b_errs", n_ferr - base_e, 0);
    check("b2b_first", (pulse_data.size() > base_q) ? pulse_data[base_q] : 8'h00, 8'h3C);
    check("b2b_second", (pulse_data.size() > base_q + 1) ? pulse_data[base_q + 1] : 8'h00, 8'hFF);
    check("b2b_data", load_data, 8'hFF);

`ifdef SERIAL_LOAD_RX_PARITY_EN
    base_p = n_pulse; base_e = n_ferr;
    start_frame();
    send_bits(16'h0003, 9);
    end_frame();
    check("par_ok_pulses", n_pulse - base_p, 1);
    check("par_ok_data", load_data, 8'h03);
    base_p = n_pulse; base_e = n_ferr;
    start_frame();
    send_bits(16'h0103, 9);
    end_frame();
    check("par_bad_errs", n_ferr - base_e, 1);
    check("par_bad_pulses", n_pulse - base_p, 0);
    check("par_bad_data", load_data, 8'h03);
`endif

    // Reset mid-frame: partial frame dropped, load_data cleared.
    base_p = n_pulse; base_e = n_ferr;
    start_frame();
    send_bits(16'h000F, 4);
    rst  = 1'b1;
    cs_n = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(12);
    check("rst_pulses", n_pulse - base_p, 0);
    check("rst_errs", n_ferr - base_e, 0);
    check("rst_data", load_data, 0);
    check("rst_busy", busy, 0);

    check("strobe_rules", n_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
